// File: rtl/pe_alu_xbar_if.sv
// pe_alu_xbar_if: configuration scan chain and datapath ports of one CGRA processing-element tile
interface pe_alu_xbar_if #(
    parameter int SIZE = 32
);
    logic            cfg_en;
    logic            cfg_in;
    logic            cfg_out;
    logic [SIZE-1:0] in0;
    logic [SIZE-1:0] in1;
    logic [SIZE-1:0] in2;
    logic [SIZE-1:0] xbar_out2;
    logic [SIZE-1:0] xbar_out3;
    logic [SIZE-1:0] out0;

    modport master (
        output cfg_en, cfg_in, in0, in1, in2,
        input  cfg_out, xbar_out2, xbar_out3, out0
    );

    modport slave (
        input  cfg_en, cfg_in, in0, in1, in2,
        output cfg_out, xbar_out2, xbar_out3, out0
    );
endinterface

// File: rtl/pe_alu_xbar.sv
// pe_alu_xbar: CGRA tile with serially configured 4x4 crossbar, registered ALU and 2x1 output switch.
// Define PE_MUL_EN to build the opcode-2 multiplier; without it opcode 2 returns zero.
module pe_alu_xbar #(
    parameter int SIZE = 32
) (
    input logic          clk,
    input logic          reset,
    pe_alu_xbar_if.slave bus
);
    localparam int SW = $clog2(SIZE);

    logic [12:0]     cfg_q, cfg_d;
    logic [SIZE-1:0] alu_q, alu_d;
    logic [SIZE-1:0] srcs [4];
    logic [SIZE-1:0] op_a, op_b, res;
    logic [3:0]      opcode;
    logic [SW-1:0]   shamt;

    assign srcs[0] = bus.in0;
    assign srcs[1] = bus.in1;
    assign srcs[2] = bus.in2;
    assign srcs[3] = alu_q;
    assign opcode  = cfg_q[12:9];
    assign op_a    = srcs[cfg_q[1:0]];
    assign op_b    = srcs[cfg_q[3:2]];
    assign shamt   = op_b[SW-1:0];

    assign bus.xbar_out2 = srcs[cfg_q[5:4]];
    assign bus.xbar_out3 = srcs[cfg_q[7:6]];
    assign bus.out0      = cfg_q[8] ? bus.in2 : alu_q;
    assign bus.cfg_out   = cfg_q[12];

    // ALU result for the current opcode and crossbar-selected operands
    always_comb begin
        res = '0;
        case (opcode)
            4'd0:  res = op_a + op_b;
            4'd1:  res = op_a - op_b;
`ifdef PE_MUL_EN
            4'd2:  res = op_a * op_b;
`else
            4'd2:  res = '0;
`endif
            4'd3:  res = op_a & op_b;
            4'd4:  res = op_a | op_b;
            4'd5:  res = op_a ^ op_b;
            4'd6:  res = op_a << shamt;
            4'd7:  res = op_a >> shamt;
            4'd8:  res = $signed(op_a) >>> shamt;
            4'd9:  res = {{(SIZE-1){1'b0}}, op_a == op_b};
            4'd10: res = {{(SIZE-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'd11: res = {{(SIZE-1){1'b0}}, op_a < op_b};
            4'd12: res = op_a;
            4'd13: res = op_b;
            4'd14: res = ($signed(op_a) < $signed(op_b)) ? op_a : op_b;
            default: res = '0;
        endcase
    end

    // shift configuration while loading; the ALU register freezes during a load
    always_comb begin
        cfg_d = bus.cfg_en ? {cfg_q[11:0], bus.cfg_in} : cfg_q;
        alu_d = bus.cfg_en ? alu_q : res;
    end

    // state registers; reset discards any partial configuration
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_q <= '0;
            alu_q <= '0;
        end else begin
            cfg_q <= cfg_d;
            alu_q <= alu_d;
        end
    end
endmodule

// File: tb/tb_pe_alu_xbar.sv
// tb_pe_alu_xbar: scoreboard bench for pe_alu_xbar against a behavioural tile model
module tb_pe_alu_xbar;
    logic clk = 1'b0;
    logic reset;

    pe_alu_xbar_if #(.SIZE(32)) bus ();
    pe_alu_xbar #(.SIZE(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          fld;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          done = 1'b0;

    logic [3:0]  m_op;
    logic        m_osel;
    logic [1:0]  m_sel [4];
    logic [31:0] m_alu;
    logic        hist[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string fname(int f);
        return f == 0 ? "out0" : f == 1 ? "xbar_out2" : f == 2 ? "xbar_out3" : "cfg_out";
    endfunction

    // monitor: compare every expectation due this cycle, then finish when stimulus is done
    always @(negedge clk) begin
        logic [31:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                act = sb[i].fld == 0 ? bus.out0 : sb[i].fld == 1 ? bus.xbar_out2 :
                      sb[i].fld == 2 ? bus.xbar_out3 : {31'b0, bus.cfg_out};
                n_checks++;
                if (act !== sb[i].exp) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: got %h expected %h", fname(sb[i].fld), cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
        if (done) begin
            n_checks++;
            if (sb.size() != 0) begin
                n_fail++;
                $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int          sa = a;
        int          sb_ = b;
        int unsigned s = b % 32;
        case (op)
            0:  return a + b;
            1:  return a - b;
`ifdef PE_MUL_EN
            2:  return 32'(64'(a) * 64'(b));
`else
            2:  return 32'd0;
`endif
            3:  return a & b;
            4:  return a | b;
            5:  return a ^ b;
            6:  return a << s;
            7:  return a >> s;
            8:  return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
            9:  return (a == b) ? 32'd1 : 32'd0;
            10: return (sa < sb_) ? 32'd1 : 32'd0;
            11: return (a < b) ? 32'd1 : 32'd0;
            12: return a;
            13: return b;
            14: return (sa < sb_) ? a : b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic push(input int fld, input logic [31:0] exp);
        sb.push_back('{cyc, fld, exp});
    endtask

    task automatic model_reset();
        m_op = 0;
        m_osel = 0;
        foreach (m_sel[i]) m_sel[i] = 0;
        m_alu = 0;
        hist.delete();
        repeat (13) hist.push_back(1'b0);
    endtask

    // one operating cycle: check combinational outputs now, predict the next ALU value
    task automatic step(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] i2);
        logic [31:0] s [4];
        bus.in0 = i0;
        bus.in1 = i1;
        bus.in2 = i2;
        s[0] = i0;
        s[1] = i1;
        s[2] = i2;
        s[3] = m_alu;
        push(0, m_osel ? i2 : m_alu);
        push(1, s[m_sel[2]]);
        push(2, s[m_sel[3]]);
        push(3, {31'b0, hist[0]});
        m_alu = ref_alu(m_op, s[m_sel[0]], s[m_sel[1]]);
        @(posedge clk); #1;
    endtask

    task automatic load(input logic [3:0] op, input logic osel, input logic [1:0] s0, input logic [1:0] s1,
                        input logic [1:0] s2, input logic [1:0] s3);
        logic [12:0] w;
        w = {op, osel, s3, s2, s1, s0};
        bus.cfg_en = 1'b1;
        for (int i = 12; i >= 0; i--) begin
            bus.cfg_in = w[i];
            push(3, {31'b0, hist[0]});
            hist.push_back(w[i]);
            void'(hist.pop_front());
            @(posedge clk); #1;
        end
        bus.cfg_en = 1'b0;
        bus.cfg_in = 1'b0;
        m_op = op;
        m_osel = osel;
        m_sel[0] = s0;
        m_sel[1] = s1;
        m_sel[2] = s2;
        m_sel[3] = s3;
    endtask

    initial begin
        reset = 1'b0;
        bus.cfg_en = 1'b0;
        bus.cfg_in = 1'b0;
        bus.in0 = '0;
        bus.in1 = '0;
        bus.in2 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        step(5, 0, 0);
        step(0, 0, 0);
        load(1, 0, 0, 1, 0, 0);
        step(3, 7, 0);
        step(0, 0, 0);
        load(0, 0, 3, 0, 0, 0);
        repeat (5) step(1, 0, 0);
        load(8, 0, 0, 1, 0, 0);
        step(32'h8000_0000, 32'h24, 0);
        load(10, 0, 0, 1, 0, 0);
        step(32'hFFFF_FFFF, 0, 0);
        load(11, 0, 0, 1, 0, 0);
        step(32'hFFFF_FFFF, 0, 0);
        load(0, 1, 0, 0, 2, 0);
        step(0, 0, 32'hDEAD_BEEF);
        load(2, 0, 0, 1, 0, 3);
        step(32'h1_0000, 32'h1_0003, 0);
        step(0, 0, 0);
        repeat (24) begin
            load(4'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
            repeat (4) step($urandom, ($urandom % 2) ? $urandom : $urandom_range(0, 40), $urandom);
        end
        bus.cfg_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.cfg_in = 1'b1;
            push(3, {31'b0, hist[0]});
            hist.push_back(1'b1);
            void'(hist.pop_front());
            @(posedge clk); #1;
        end
        reset = 1'b0;
        bus.cfg_en = 1'b0;
        bus.in0 = 32'h1234;
        model_reset();
        push(0, 0);
        push(1, 32'h1234);
        push(3, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        step(5, 0, 0);
        step(0, 0, 0);
        done = 1'b1;
        repeat (4) @(posedge clk);
        $display("FAIL monitor_timeout: got no summary expected summary");
        $fatal(1);
    end
endmodule

// File: doc/pe_alu_xbar.md
# pe_alu_xbar

Single-cycle processing-element tile for the CGRA fabric: a serially configured 4x4 input crossbar feeds a two-operand registered ALU, and a 2x1 output switch drives the tile output. Configuration shifts in over a one-bit scan chain that daisy-chains tile to tile on the datapath clock. The tile sits between neighbouring interconnect ports (`in0`/`in1`), a sibling memory-unit result (`in2`) and the downstream network (`out0`).

## Interface
- `SIZE`, 32, datapath width in bits (power of two, ≥8)
- `clk` input 1 — single clock for datapath and configuration
- `reset` input 1 — asynchronous, active-low; clears configuration and ALU register
- `cfg_en` input 1 — configuration shift enable
- `cfg_in` input 1 — serial configuration data in
- `cfg_out` output 1 — serial configuration data out (to next tile)
- `in0` input SIZE — neighbour port 0
- `in1` input SIZE — neighbour port 1
- `in2` input SIZE — sibling memory-unit result
- `xbar_out2` output SIZE — crossbar output 2 (to sibling memory address)
- `xbar_out3` output SIZE — crossbar output 3 (to sibling memory data)
- `out0` output SIZE — tile output

## Operation
- Config register `cfg[12:0]`, 13 bits. On `clk` rising with `cfg_en`=1: `cfg <= {cfg[11:0], cfg_in}`; `cfg_out` = `cfg[12]` (registered, no combinational path `cfg_in`→`cfg_out`).
- Fields: `cfg[12:9]` ALU opcode; `cfg[8]` output select; `cfg[7:0]` crossbar, `sel_k = cfg[2k+1:2k]` for crossbar output k=0..3. Full load = 13 shifts, first bit shifted ends in `cfg[12]`.
- Crossbar (combinational): sources 0=`in0`, 1=`in1`, 2=`in2`, 3=`alu_q`. Outputs 0/1 are ALU operands A/B; outputs 2/3 drive `xbar_out2`/`xbar_out3`. Any source may fan out to several outputs.
- ALU opcodes (A,B → result, SIZE bits, wrap-around, no flags): 0 ADD A+B; 1 SUB A−B; 2 MUL low SIZE bits of A*B; 3 AND; 4 OR; 5 XOR; 6 SHL A<<B[log2(SIZE)-1:0]; 7 SHR logical; 8 ASHR arithmetic; 9 EQ (A==B ? 1 : 0); 10 LT signed; 11 LTU unsigned; 12 PASS A; 13 PASS B; 14 MIN signed; 15 result 0.
- Shift amount uses only low log2(SIZE) bits of B; upper bits ignored.
- Output switch (combinational): `cfg[8]`=0 → `out0`=`alu_q`; 1 → `out0`=`in2`.

## Timing
- Reset (async assert, sync release on `clk`): `cfg`=0, `alu_q`=0, so `cfg_out`=0, `out0`=0, all crossbar selects = `in0`, opcode ADD, output select ALU.
- ALU latency 1 cycle: `alu_q` <= f(A,B) every `clk` rise while `cfg_en`=0.
- While `cfg_en`=1: `alu_q` holds its value; crossbar/out switch follow the shifting `cfg` combinationally (outputs undefined-but-deterministic during load; consumers ignore them).
- `cfg_en` deasserted: new configuration effective same cycle combinationally; first ALU result with new opcode appears one cycle later.
- Feedback via source 3 uses registered `alu_q`; no combinational loops (accumulate: A=`alu_q`, B=`in0`, ADD).
- Reset mid-load discards partial configuration.

## Configuration
- `PE_MUL_EN` defined: opcode 2 is a SIZE×SIZE multiply, low SIZE bits.
- Not defined: no multiplier instantiated; opcode 2 yields 0. All other opcodes unchanged.

## Test plan
- Reset, `in0`=5, `cfg_en`=0, one clk → `out0`=10 (ADD in0+in0); `cfg_out`=0.
- Shift 13 bits for opcode 1, sel0=0, sel1=1, out sel 0; `in0`=3, `in1`=7 → next cycle `out0`=0xFFFFFFFC; `cfg_out` during shift equals `cfg_in` delayed 13 cycles.
- Accumulator: opcode 0, sel0=3, sel1=0, `in0`=1, from `alu_q`=0 → `out0` = 1,2,3,4 on successive cycles.
- Opcode 8, A=0x80000000, B=0x24 → 0xF8000000 (shift by 4); opcode 10 A=−1, B=0 → 1; opcode 11 same → 0.
- Output select 1, `in2`=0xDEADBEEF → `out0`=0xDEADBEEF same cycle; `xbar_out2` with sel2=2 also 0xDEADBEEF.
- Opcode 2, A=0x10000, B=0x10003: with `PE_MUL_EN` → 0x30000; without → 0.
